// File: rtl/viterbi_tb_mem_ctrl.sv
// rtl/viterbi_tb_mem_ctrl.sv - survivor RAM scheduler: ACS row writes and traceback reads
// Writes always win the RAM port; traceback reads fill the idle cycles.
module viterbi_tb_mem_ctrl #(
   parameter int NROWS     = 64,
   parameter int ADDR_BITS = 6,
   parameter int NBITS     = 4,
   parameter int TB_LEN    = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 dec_valid,
   output logic                 dec_ready,
   input  logic [NBITS-1:0]     dec_bits,
   input  logic                 tb_start,
   input  logic [1:0]           tb_state,
   output logic                 tb_busy,
   output logic                 bit_valid,
   output logic                 bit_out,
   output logic                 tb_done,
   output logic                 ram_rws,
   output logic                 ram_cs,
   output logic [ADDR_BITS-1:0] ram_cr,
   output logic [NBITS-1:0]     ram_i,
   input  logic [NBITS-1:0]     ram_o
);

   localparam logic [ADDR_BITS:0]   FILL_MAX = (ADDR_BITS+1)'(NROWS);
   localparam logic [ADDR_BITS:0]   FILL_MIN = (ADDR_BITS+1)'(TB_LEN);
   localparam logic [ADDR_BITS:0]   FILL_ONE = (ADDR_BITS+1)'(1);
   localparam logic [ADDR_BITS-1:0] ONE_A    = ADDR_BITS'(1);
   localparam logic [ADDR_BITS-1:0] LEN_A    = ADDR_BITS'(TB_LEN);
   localparam logic [ADDR_BITS-1:0] LAST_CNT = ADDR_BITS'(TB_LEN - 1);

   typedef enum logic [1:0] {IDLE, TRACE, DONE} state_t;

   state_t               state;
   logic [ADDR_BITS-1:0] wp;
   logic [ADDR_BITS-1:0] rd;
   logic [ADDR_BITS-1:0] guard;
   logic [ADDR_BITS-1:0] cnt;
   logic [ADDR_BITS:0]   fill;
   logic [1:0]           st;
   logic                 wr;
   logic                 rd_en;
   logic                 d;

   // Stop writing once the next write would land on the oldest row of the window.
   assign dec_ready = rst_n && !(state == TRACE && wp == guard);
   assign wr        = dec_valid && dec_ready;
   assign rd_en     = (state == TRACE) && !wr;
   assign ram_cs    = wr || rd_en;
   assign ram_rws   = wr;
   assign ram_cr    = wr ? wp : rd;
   assign ram_i     = dec_bits;
   assign d         = ram_o[st];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wp        <= '0;
         rd        <= '0;
         guard     <= '0;
         cnt       <= '0;
         fill      <= '0;
         st        <= '0;
         tb_busy   <= 1'b0;
         bit_valid <= 1'b0;
         bit_out   <= 1'b0;
         tb_done   <= 1'b0;
      end else begin
         if (wr) begin
            wp <= wp + ONE_A;
            if (fill != FILL_MAX)
               fill <= fill + FILL_ONE;
         end
         case (state)
            IDLE: begin
               bit_valid <= 1'b0;
               tb_done   <= 1'b0;
               if (tb_start && fill >= FILL_MIN) begin
                  state   <= TRACE;
                  tb_busy <= 1'b1;
                  st      <= tb_state;
                  rd      <= wp - ONE_A;
                  guard   <= wp - LEN_A;
                  cnt     <= '0;
               end
            end
            TRACE: begin
               if (wr) begin
                  bit_valid <= 1'b0;
               end else begin
                  bit_valid <= 1'b1;
                  bit_out   <= st[1];
                  st        <= {st[0], d};
                  rd        <= rd - ONE_A;
                  cnt       <= cnt + ONE_A;
                  if (cnt == LAST_CNT) begin
                     state   <= DONE;
                     tb_busy <= 1'b0;
                     tb_done <= 1'b1;
                  end
               end
            end
            DONE: begin
               state     <= IDLE;
               bit_valid <= 1'b0;
               tb_done   <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_viterbi_tb_mem_ctrl.sv
// tb/tb_viterbi_tb_mem_ctrl.sv - directed bench for viterbi_tb_mem_ctrl
// Includes a behavioural single-port RAM with tristated read data.
module tb_viterbi_tb_mem_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       dec_valid = 1'b0;
   logic       dec_ready;
   logic [3:0] dec_bits = 4'h0;
   logic       tb_start = 1'b0;
   logic [1:0] tb_state = 2'b00;
   logic       tb_busy;
   logic       bit_valid;
   logic       bit_out;
   logic       tb_done;
   logic       ram_rws;
   logic       ram_cs;
   logic [5:0] ram_cr;
   logic [3:0] ram_i;
   wire  [3:0] ram_o;

   logic [3:0] mem [64];
   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (ram_cs && ram_rws) mem[ram_cr] <= ram_i;
   assign ram_o = (ram_cs && !ram_rws) ? mem[ram_cr] : 4'bzzzz;

   viterbi_tb_mem_ctrl dut (
      .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_bits(dec_bits), .tb_start(tb_start), .tb_state(tb_state), .tb_busy(tb_busy),
      .bit_valid(bit_valid), .bit_out(bit_out), .tb_done(tb_done), .ram_rws(ram_rws),
      .ram_cs(ram_cs), .ram_cr(ram_cr), .ram_i(ram_i), .ram_o(ram_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic write_rows(input int n, input logic [3:0] val);
      dec_bits  = val;
      dec_valid = 1'b1;
      repeat (n) @(posedge clk);
      #1 dec_valid = 1'b0;
   endtask

   // One traceback: checks read order, window protection, bits, strobe count and timing.
   task automatic trace(input string tag, input logic [1:0] st, input int exp_start,
                        input logic [31:0] exp_bits, input bit contend, input bit poke);
      int k = 0, nbits = 0, nrd = 0, nwr = 0, nstall = 0;
      int rd_bad = 0, win_bad = 0, first_k = 0, done_k = 0, done_at = 0, extra = 0;
      int exp_rd = exp_start;
      logic [31:0] got = '0;
      tb_state = st;
      tb_start = 1'b1;
      @(posedge clk);
      #1 tb_start = 1'b0;
      if (contend) dec_valid = 1'b1;
      while (k < 200 && done_k == 0) begin
         if (poke) tb_start = (k == 4);
         #1;
         if (ram_cs && !ram_rws) begin
            nrd++;
            if (ram_cr != exp_rd[5:0]) rd_bad++;
            exp_rd = (exp_rd + 63) % 64;
         end
         if (ram_cs && ram_rws) begin
            nwr++;
            if (((exp_start - int'(ram_cr) + 64) % 64) < 32) win_bad++;
         end
         if (dec_valid && !dec_ready) nstall++;
         @(posedge clk);
         #1 k++;
         if (bit_valid) begin
            if (nbits == 0) first_k = k;
            if (nbits < 32) got[nbits] = bit_out;
            nbits++;
         end
         if (tb_done) begin
            done_k  = k;
            done_at = nbits;
         end
      end
      tb_start = 1'b0;
      check({tag, "_timeout"}, (done_k != 0), 1);
      check({tag, "_bits"}, got, exp_bits);
      check({tag, "_nstrobe"}, nbits, 32);
      check({tag, "_done_on_last"}, done_at, 32);
      check({tag, "_nreads"}, nrd, 32);
      check({tag, "_rd_seq"}, rd_bad, 0);
      check({tag, "_window"}, win_bad, 0);
      if (contend) begin
         check({tag, "_nwrites"}, nwr, 32);
         check({tag, "_nstall"}, nstall, 32);
         check({tag, "_len"}, done_k, 64);
      end else begin
         check({tag, "_first_lat"}, first_k, 1);
         check({tag, "_len"}, done_k, 32);
      end
      @(posedge clk);
      #1 check({tag, "_ready_idle"}, dec_ready, 1);
      dec_valid = 1'b0;
      if (tb_done || bit_valid || tb_busy) extra++;
      repeat (3) begin
         @(posedge clk);
         #1 if (tb_done || bit_valid || tb_busy) extra++;
      end
      check({tag, "_quiet_after"}, extra, 0);
   endtask

   initial begin
      int cnt_spur;
      #2;
      check("rst_outs", {tb_busy, bit_valid, bit_out, tb_done, ram_cs, dec_ready}, 6'b0);
      @(negedge clk) rst_n = 1'b1;
      #1;
      check("rst_ready", dec_ready, 1);
      check("rst_cs", ram_cs, 0);

      write_rows(32, 4'h0);
      trace("zero", 2'b00, 31, 32'h0000_0000, 1'b0, 1'b1);

      write_rows(32, 4'hF);
      trace("ones", 2'b00, 63, 32'hFFFF_FFFC, 1'b0, 1'b0);

      // Abort a traceback with an asynchronous reset in mid-cycle.
      tb_state = 2'b01;
      tb_start = 1'b1;
      @(posedge clk);
      #1 tb_start = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check("midrst_outs", {tb_busy, bit_valid, bit_out, tb_done, ram_cs}, 5'b0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      cnt_spur = 0;
      repeat (40) begin
         @(posedge clk);
         #1 if (tb_done || bit_valid || tb_busy) cnt_spur++;
      end
      check("midrst_no_done", cnt_spur, 0);
      dec_bits  = 4'h0;
      dec_valid = 1'b1;
      #1 check("midrst_wp0", {ram_cs, ram_rws, ram_cr}, {1'b1, 1'b1, 6'd0});
      repeat (10) @(posedge clk);
      #1 dec_valid = 1'b0;

      tb_state = 2'b00;
      tb_start = 1'b1;
      @(posedge clk);
      #1 tb_start = 1'b0;
      cnt_spur = 0;
      repeat (5) begin
         if (ram_cs) cnt_spur++;
         @(posedge clk);
         #1 if (tb_busy || bit_valid || tb_done) cnt_spur++;
      end
      check("short_fill_ignored", cnt_spur, 0);

      write_rows(60, 4'h0);
      trace("wrap", 2'b11, 5, 32'h0000_0003, 1'b0, 1'b0);
      trace("contend", 2'b10, 5, 32'h0000_0001, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
